uart_rx_os: RTL and testbench

//  Parametrised UART receiver with input synchroniser, OVERSAMPLE-x mid-bit majority vote, 5..9 data bits,

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_rx_os.sv | 249 ++++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared receiver/transmitter state codes, parity modes and vote helper.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module  : uart_baud_tick
// Brief   : Oversample tick generator; restart re-phases the divider to an edge.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rstb,
  input  logic restart,
  output logic tick
);

  localparam int c_div = (CLK_FREQ + (BAUDRATE * OVERSAMPLE) / 2) / (BAUDRATE * OVERSAMPLE);
  localparam int c_cw  = (c_div < 2) ? 1 : $clog2(c_div + 1);
  localparam logic [c_cw-1:0] c_last = c_cw'(c_div - 1);

  logic [c_cw-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_cnt <= '0;
    end else if (restart || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cw'(1);
    end
  end

  assign tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_rx_os.sv
// ============================================================================
// Module  : uart_rx_os
// Brief   : Oversampling UART receiver, 3-sample mid-bit vote, valid/ready out.
//           Define UART_RX_BREAK_DET_EN to enable line-break detection.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUDRATE    = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int BITLEN      = 8,
  parameter int PARITY      = 0,
  parameter int STOPBITS    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              rx,
  output logic [BITLEN-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              break_det
);

  localparam int c_osw = $clog2(OVERSAMPLE);
  localparam int c_bw  = $clog2(BITLEN + 1);
  localparam logic [c_osw-1:0] c_smp0     = c_osw'(OVERSAMPLE / 2 - 1);
  localparam logic [c_osw-1:0] c_smp1     = c_osw'(OVERSAMPLE / 2);
  localparam logic [c_osw-1:0] c_vote     = c_osw'(OVERSAMPLE / 2 + 1);
  localparam logic [c_osw-1:0] c_os_last  = c_osw'(OVERSAMPLE - 1);
  localparam logic [c_bw-1:0]  c_bit_last = c_bw'(BITLEN - 1);
  localparam logic [c_bw-1:0]  c_stop_last = c_bw'(STOPBITS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx;
  logic [2:0]             r_state;
  logic                   w_restart;
  logic                   w_tick;
  logic                   w_at_vote;
  logic                   w_at_last;
  logic                   w_vote;
  logic [c_osw-1:0]       r_os_cnt;
  logic [c_bw-1:0]        r_bit_idx;
  logic [1:0]             r_smp;
  logic [BITLEN-1:0]      r_shift;
  logic                   r_par_bit;
  logic                   r_ferr_acc;
  logic                   w_ferr_now;
  logic                   w_perr;
  logic                   w_last_stop;
  logic                   w_is_break;
  logic                   w_done;
  logic                   w_accept;
  logic [BITLEN-1:0]      r_data_out;
  logic                   r_data_valid;
  logic                   r_parity_err;
  logic                   r_frame_err;
  logic                   r_overrun;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
  end

  assign w_rx      = r_sync[SYNC_STAGES-1];
  assign w_restart = (r_state == S_IDLE) && !w_rx;

  uart_baud_tick #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUDRATE   (BAUDRATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_tick (
    .clk     (clk),
    .rstb    (rstb),
    .restart (w_restart),
    .tick    (w_tick)
  );

  assign w_at_vote   = w_tick && (r_os_cnt == c_vote);
  assign w_at_last   = w_tick && (r_os_cnt == c_os_last);
  assign w_vote      = maj3(r_smp[0], r_smp[1], w_rx);
  assign w_ferr_now  = r_ferr_acc | ~w_vote;
  assign w_last_stop = (r_state == S_STOP) && w_at_vote && (r_bit_idx == c_stop_last);

  always_comb begin
    w_perr = 1'b0;
    if (PARITY == PARITY_EVEN) begin
      w_perr = ^{r_shift, r_par_bit};
    end else if (PARITY == PARITY_ODD) begin
      w_perr = ~^{r_shift, r_par_bit};
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // r_zero: parity and earlier stop votes were all 0 in the current frame.
  logic r_zero;
  logic r_break_det;
  assign w_is_break = r_zero && (r_shift == '0) && !w_vote;
  assign break_det  = r_break_det;
`else
  assign w_is_break = 1'b0;
  assign break_det  = 1'b0;
`endif

  assign w_done = w_last_stop && !w_is_break;

  // Sample counter runs only inside a frame; first two vote samples are latched.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_os_cnt <= '0;
      r_smp    <= '0;
    end else if (r_state == S_IDLE) begin
      r_os_cnt <= '0;
    end else if (w_tick) begin
      if (r_os_cnt == c_smp0) r_smp[0] <= w_rx;
      if (r_os_cnt == c_smp1) r_smp[1] <= w_rx;
      r_os_cnt <= (r_os_cnt == c_os_last) ? '0 : r_os_cnt + c_osw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state    <= S_IDLE;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_ferr_acc <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_zero      <= 1'b1;
      r_break_det <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_BREAK_DET_EN
      r_break_det <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_state    <= S_START;
            r_bit_idx  <= '0;
            r_ferr_acc <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            r_zero     <= 1'b1;
`endif
          end
        end
        S_START: begin
          if (w_at_vote && w_vote) begin
            r_state <= S_IDLE;
          end else if (w_at_last) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_at_vote) r_shift <= {w_vote, r_shift[BITLEN-1:1]};
          if (w_at_last) begin
            if (r_bit_idx == c_bit_last) begin
              r_bit_idx <= '0;
              r_state   <= (PARITY == PARITY_NONE) ? S_STOP : S_PARITY;
            end else begin
              r_bit_idx <= r_bit_idx + c_bw'(1);
            end
          end
        end
        S_PARITY: begin
          if (w_at_vote) begin
            r_par_bit <= w_vote;
`ifdef UART_RX_BREAK_DET_EN
            r_zero    <= r_zero & ~w_vote;
`endif
          end
          if (w_at_last) r_state <= S_STOP;
        end
        S_STOP: begin
          // Leave right after the last stop vote so a following start edge is caught.
          if (w_at_vote) begin
            r_ferr_acc <= w_ferr_now;
`ifdef UART_RX_BREAK_DET_EN
            r_zero     <= r_zero & ~w_vote;
`endif
            if (r_bit_idx == c_stop_last) begin
`ifdef UART_RX_BREAK_DET_EN
              if (w_is_break) begin
                r_state     <= S_BREAK;
                r_break_det <= 1'b1;
              end else
`endif
              r_state <= S_IDLE;
            end
          end else if (w_at_last) begin
            r_bit_idx <= r_bit_idx + c_bw'(1);
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        S_BREAK: begin
          if (w_rx) r_state <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_accept = r_data_valid && data_ready;

  // A completion coinciding with an accept replaces the word without overrun.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_done) begin
        if (!r_data_valid || w_accept) begin
          r_data_out   <= r_shift;
          r_parity_err <= w_perr;
          r_frame_err  <= w_ferr_now;
          r_data_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_os.sv
// ============================================================================
// Module  : tb_uart_rx_os
// Brief   : Directed bench for uart_rx_os (8N1 and 8E1 instances, 16 clk/bit).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_os;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUDRATE   = 100_000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = 16;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic rx_a = 1'b1;
  logic rx_p = 1'b1;
  logic ready_a = 1'b1;
  logic ready_p = 1'b1;
  logic [7:0] dout_a, dout_p;
  logic dv_a, dv_p, perr_a, perr_p, ferr_a, ferr_p, ovr_a, ovr_p, brk_a, brk_p;

  int total = 0;
  int bad = 0;
  exp_t qa[$];
  exp_t qp[$];
  int valid_cyc_a = 0;
  int ovr_cyc_a = 0;
  int brk_cyc_a = 0;
  logic [7:0] last_a = 8'h00;
  logic       last_fe_a = 1'b0;
  logic       last_pe_p = 1'b0;

  always #5 clk = ~clk;

  uart_rx_os #(
    .CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUDRATE), .OVERSAMPLE(OVERSAMPLE),
    .BITLEN(8), .PARITY(0), .STOPBITS(1), .SYNC_STAGES(2)
  ) u_dut (
    .clk(clk), .rstb(rstb), .rx(rx_a), .data_out(dout_a), .data_valid(dv_a),
    .data_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a),
    .overrun(ovr_a), .break_det(brk_a)
  );

  uart_rx_os #(
    .CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUDRATE), .OVERSAMPLE(OVERSAMPLE),
    .BITLEN(8), .PARITY(1), .STOPBITS(1), .SYNC_STAGES(2)
  ) u_dut_par (
    .clk(clk), .rstb(rstb), .rx(rx_p), .data_out(dout_p), .data_valid(dv_p),
    .data_ready(ready_p), .parity_err(perr_p), .frame_err(ferr_p),
    .overrun(ovr_p), .break_det(brk_p)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected words: the held word must match the queue head every cycle it is valid.
  always @(negedge clk) begin
    if (rstb) begin
      if (ovr_a) ovr_cyc_a++;
      if (brk_a) brk_cyc_a++;
      if (dv_a) begin
        valid_cyc_a++;
        if (qa.size() == 0) begin
          chk("a_unexpected_valid", {31'd0, dv_a}, 32'd0);
        end else begin
          chk("a_data", {24'd0, dout_a}, {24'd0, qa[0].d});
          chk("a_perr", {31'd0, perr_a}, {31'd0, qa[0].pe});
          chk("a_ferr", {31'd0, ferr_a}, {31'd0, qa[0].fe});
          if (ready_a) begin
            last_a    = dout_a;
            last_fe_a = ferr_a;
            void'(qa.pop_front());
          end
        end
      end
      if (dv_p) begin
        if (qp.size() == 0) begin
          chk("p_unexpected_valid", {31'd0, dv_p}, 32'd0);
        end else begin
          chk("p_data", {24'd0, dout_p}, {24'd0, qp[0].d});
          chk("p_perr", {31'd0, perr_p}, {31'd0, qp[0].pe});
          chk("p_ferr", {31'd0, ferr_p}, {31'd0, qp[0].fe});
          last_pe_p = perr_p;
          void'(qp.pop_front());
        end
      end
      chk("p_no_overrun", {31'd0, ovr_p}, 32'd0);
      chk("p_no_break", {31'd0, brk_p}, 32'd0);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d, input logic stop_v);
    exp_t e;
    e.d = d; e.pe = 1'b0; e.fe = ~stop_v;
    qa.push_back(e);
  endtask

  // spike_bit >= 0 inverts that data bit for one clock near its middle.
  task automatic send_a(input logic [7:0] d, input logic stop_v, input int spike_bit);
    rx_a = 1'b0;
    wait_clk(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_a = d[i];
      if (i == spike_bit) begin
        wait_clk(9);
        rx_a = ~d[i];
        wait_clk(1);
        rx_a = d[i];
        wait_clk(BIT_CLKS - 10);
      end else begin
        wait_clk(BIT_CLKS);
      end
    end
    rx_a = stop_v;
    wait_clk(BIT_CLKS);
    rx_a = 1'b1;
  endtask

  task automatic send_p(input logic [7:0] d, input logic p);
    exp_t e;
    e.d = d; e.pe = ^{d, p}; e.fe = 1'b0;
    qp.push_back(e);
    rx_p = 1'b0;
    wait_clk(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_p = d[i];
      wait_clk(BIT_CLKS);
    end
    rx_p = p;
    wait_clk(BIT_CLKS);
    rx_p = 1'b1;
    wait_clk(BIT_CLKS);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && (qa.size() != 0 || qp.size() != 0); i++) @(posedge clk);
    #1;
    chk(tag, qa.size() + qp.size(), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_data"},  {24'd0, dout_a}, 32'd0);
    chk({tag, "_valid"}, {31'd0, dv_a}, 32'd0);
    chk({tag, "_perr"},  {31'd0, perr_a}, 32'd0);
    chk({tag, "_ferr"},  {31'd0, ferr_a}, 32'd0);
    chk({tag, "_ovr"},   {31'd0, ovr_a}, 32'd0);
    chk({tag, "_brk"},   {31'd0, brk_a}, 32'd0);
    chk({tag, "_pvalid"}, {31'd0, dv_p}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int v0;
    int o0;
    int b0;
    exp_t e;

    // Reset state
    rstb = 1'b0;
    wait_clk(3);
    chk_reset_outputs("reset");
    rstb = 1'b1;
    wait_clk(40);

    // 8N1 0xA5 with consumer ready: one-cycle valid
    ready_a = 1'b1;
    v0 = valid_cyc_a;
    push_a(8'hA5, 1'b1);
    send_a(8'hA5, 1'b1, -1);
    wait_clk(2 * BIT_CLKS);
    drain("a5_drain");
    chk("a5_valid_cycles", valid_cyc_a - v0, 32'd1);
    chk("a5_literal", {24'd0, last_a}, 32'h0000_00A5);

    // Even parity instance, 0x3C with wrong then correct parity bit
    send_p(8'h3C, 1'b1);
    wait_clk(BIT_CLKS);
    chk("par1_literal", {31'd0, last_pe_p}, 32'd1);
    send_p(8'h3C, 1'b0);
    wait_clk(BIT_CLKS);
    chk("par0_literal", {31'd0, last_pe_p}, 32'd0);
    drain("par_drain");

    // Stop bit low, then a clean frame
    push_a(8'h55, 1'b0);
    send_a(8'h55, 1'b0, -1);
    wait_clk(2 * BIT_CLKS);
    chk("ferr_literal", {31'd0, last_fe_a}, 32'd1);
    push_a(8'h12, 1'b1);
    send_a(8'h12, 1'b1, -1);
    wait_clk(2 * BIT_CLKS);
    drain("ferr_drain");
    chk("after_ferr_literal", {24'd0, last_a}, 32'h0000_0012);

    // Back-to-back frames with consumer stalled: second word dropped
    ready_a = 1'b0;
    o0 = ovr_cyc_a;
    push_a(8'h11, 1'b1);
    send_a(8'h11, 1'b1, -1);
    send_a(8'h22, 1'b1, -1);
    wait_clk(3 * BIT_CLKS);
    chk("ovr_pulses", ovr_cyc_a - o0, 32'd1);
    chk("ovr_held_valid", {31'd0, dv_a}, 32'd1);
    chk("ovr_held_literal", {24'd0, dout_a}, 32'h0000_0011);
    ready_a = 1'b1;
    wait_clk(2);
    chk("ovr_valid_fell", {31'd0, dv_a}, 32'd0);
    drain("ovr_drain");

    // Short glitch in idle: no word
    v0 = valid_cyc_a;
    rx_a = 1'b0;
    wait_clk(6);
    rx_a = 1'b1;
    wait_clk(3 * BIT_CLKS);
    chk("glitch_no_valid", valid_cyc_a - v0, 32'd0);

    // One-clock spike in data bit 4 of 0xF0
    push_a(8'hF0, 1'b1);
    send_a(8'hF0, 1'b1, 4);
    wait_clk(2 * BIT_CLKS);
    drain("spike_drain");
    chk("spike_literal", {24'd0, last_a}, 32'h0000_00F0);

    // Line held low for 20 bit times
    ready_a = 1'b0;
    b0 = brk_cyc_a;
`ifndef UART_RX_BREAK_DET_EN
    push_a(8'h00, 1'b0);
`endif
    rx_a = 1'b0;
    wait_clk(20 * BIT_CLKS);
    rx_a = 1'b1;
    wait_clk(15 * BIT_CLKS);
`ifdef UART_RX_BREAK_DET_EN
    chk("brk_pulses", brk_cyc_a - b0, 32'd1);
    chk("brk_no_valid", {31'd0, dv_a}, 32'd0);
`else
    chk("brk_disabled_pulses", brk_cyc_a - b0, 32'd0);
    chk("brk_as_data_valid", {31'd0, dv_a}, 32'd1);
    chk("brk_as_data_literal", {24'd0, dout_a}, 32'd0);
    chk("brk_as_data_ferr", {31'd0, ferr_a}, 32'd1);
`endif
    ready_a = 1'b1;
    wait_clk(2);
    chk("brk_idle_valid", {31'd0, dv_a}, 32'd0);
    drain("brk_drain");

    // Reset in the middle of a data phase while a word is held
    ready_a = 1'b0;
    push_a(8'h77, 1'b1);
    send_a(8'h77, 1'b1, -1);
    wait_clk(2 * BIT_CLKS);
    chk("pre_reset_held", {31'd0, dv_a}, 32'd1);
    rx_a = 1'b0;
    wait_clk(BIT_CLKS);
    rx_a = 1'b0;
    wait_clk(2 * BIT_CLKS);
    rx_a = 1'b1;
    wait_clk(BIT_CLKS / 2);
    rstb = 1'b0;
    qa.delete();
    wait_clk(2);
    chk_reset_outputs("midreset");
    rstb = 1'b1;
    wait_clk(3 * BIT_CLKS);
    ready_a = 1'b1;
    push_a(8'h81, 1'b1);
    send_a(8'h81, 1'b1, -1);
    wait_clk(2 * BIT_CLKS);
    drain("post_reset_drain");
    chk("post_reset_literal", {24'd0, last_a}, 32'h0000_0081);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
